// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and sequencer for an 8:1 single-bit mux.
// Eight requesters share one mux output. The block grants one requester at a
// time and drives the 3-bit select. It also registers the selected data bit
// and pulses a valid strobe for it.
//
// Handshake: req[i] stays high until requester i has been served. gnt is one-hot,
// or zero when idle. muxout_vld is high in the cycle after each grant cycle and
// qualifies muxout, which is the a[sel] value sampled during that grant cycle.
//
// Optional feature: define MUX_ARB_LOCK_EN to add the lock input. While lock
// is high, the current owner keeps its grant past MAX_HOLD for as long as it
// holds its request.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4  // 1..15 consecutive grant cycles per owner
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] a,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       muxout,
  output logic       muxout_vld,
  output logic       state_dbg   // 1 while in GRANT, for observation only
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_q;
  logic [7:0] gnt_q;
  logic [2:0] sel_q;
  logic       muxout_q;
  logic       vld_q;
  logic [2:0] ptr_q;
  logic [3:0] hold_cnt_q;

  logic       any_req;
  logic       owner_req;
  logic       hold_max;
  logic       lock_hold;
  logic       release_c;
  logic [2:0] scan_base;
  logic [2:0] winner;

  // Return the first index with a request, scanning upward from base and
  // wrapping around. The loop runs downward so that the smallest offset wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
    logic [2:0] idx;
    rr_pick = base;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Release decision and next winner. On release, the scan restarts just past
  // the current owner so that a new grant follows in the same cycle.
  always_comb begin
    any_req   = |req;
    owner_req = req[sel_q];
    hold_max  = (hold_cnt_q == MAX_HOLD_C);
    lock_hold = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lock_hold = lock & owner_req;
`endif
    release_c = !owner_req || (hold_max && !lock_hold);
    scan_base = (state_q == GRANT) ? (sel_q + 3'd1) : ptr_q;
    winner    = rr_pick(req, scan_base);
  end

  // Arbitration FSM with registered grant, select and datapath outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 8'h00;
      sel_q      <= 3'd0;
      muxout_q   <= 1'b0;
      vld_q      <= 1'b0;
      ptr_q      <= 3'd0;
      hold_cnt_q <= 4'd0;
    end else begin
      vld_q <= (state_q == GRANT);
      if (state_q == GRANT) muxout_q <= a[sel_q];

      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q    <= GRANT;
            gnt_q      <= 8'(1) << winner;
            sel_q      <= winner;
            hold_cnt_q <= 4'd1;
          end
        end
        GRANT: begin
          if (release_c) begin
            ptr_q <= sel_q + 3'd1;
            if (any_req) begin
              gnt_q      <= 8'(1) << winner;
              sel_q      <= winner;
              hold_cnt_q <= 4'd1;
            end else begin
              state_q    <= IDLE;
              gnt_q      <= 8'h00;
              hold_cnt_q <= 4'd0;
            end
          end else begin
            // The count can only sit at the limit here while lock is holding the
            // grant. In that case it saturates instead of wrapping.
            hold_cnt_q <= hold_max ? hold_cnt_q : hold_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign muxout     = muxout_q;
  assign muxout_vld = vld_q;
  assign state_dbg  = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter, built with the default MAX_HOLD of 4.
// The expected values below are worked out by hand from the intended behaviour.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] a;
  logic       lock;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       muxout;
  logic       muxout_vld;
  logic       state_dbg;

  int n_checks = 0;
  int n_fails  = 0;

  // Clock and reset
  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a          (a),
`ifdef MUX_ARB_LOCK_EN
    .lock       (lock),
`endif
    .gnt        (gnt),
    .sel        (sel),
    .muxout     (muxout),
    .muxout_vld (muxout_vld),
    .state_dbg  (state_dbg)
  );

  // Driver: advance one rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    lock  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard check: one comparison
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    a     = 8'h00;
    lock  = 1'b0;

    // 1: held in reset with all requests high
    req = 8'hFF;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h00);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_vld", 32'(muxout_vld), 32'd0);
    check("rst_mux", 32'(muxout), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // 2: single requester 3 with a[3]=1
    rst_n = 1'b1;
    req   = 8'h08;
    a     = 8'h08;
    tick();
    check("t2_gnt", 32'(gnt), 32'h08);
    check("t2_sel", 32'(sel), 32'd3);
    check("t2_vld0", 32'(muxout_vld), 32'd0);
    tick();
    check("t2_mux", 32'(muxout), 32'd1);
    check("t2_vld1", 32'(muxout_vld), 32'd1);
    // The grant passes through the MAX_HOLD limit and is re-granted with no gap.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_hold_gnt", 32'(gnt), 32'h08);
      check("t2_hold_vld", 32'(muxout_vld), 32'd1);
    end
    a = 8'hF7;  // bit 3 low; the other bits must not leak through
    tick();
    check("t2_mux0", 32'(muxout), 32'd0);
    req = 8'h00;
    tick();
    check("t2_idle_gnt", 32'(gnt), 32'h00);
    check("t2_idle_vld", 32'(muxout_vld), 32'd1);
    check("t2_idle_sel", 32'(sel), 32'd3);
    tick();
    check("t2_idle_vld2", 32'(muxout_vld), 32'd0);

    // 3: all requesting; each owner holds for 4 cycles in turn
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      tick();
      check("t3_gnt", 32'(gnt), 32'(8'(1) << ((k / 4) % 8)));
      check("t3_sel", 32'(sel), 32'((k / 4) % 8));
    end

    // 4: owner 7 drops its request while 2 waits; the scan wraps past 0 and 1
    do_reset();
    req = 8'h80;
    tick();
    check("t4_gnt7", 32'(gnt), 32'h80);
    req = 8'h84;
    tick();
    check("t4_keep7", 32'(gnt), 32'h80);
    req = 8'h04;
    tick();
    check("t4_gnt2", 32'(gnt), 32'h04);
    check("t4_sel2", 32'(sel), 32'd2);

    // 5: reset in the middle of a grant to 5
    do_reset();
    req = 8'h20;
    tick();
    check("t5_gnt5", 32'(gnt), 32'h20);
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_rst_gnt", 32'(gnt), 32'h00);
    check("t5_rst_sel", 32'(sel), 32'd0);
    check("t5_rst_vld", 32'(muxout_vld), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t5_regnt", 32'(gnt), 32'h20);
    check("t5_resel", 32'(sel), 32'd5);

    // 6: owner 5 with everyone requesting
    do_reset();
    req = 8'h20;
    tick();
    check("t6_gnt5", 32'(gnt), 32'h20);
    req = 8'hFF;
`ifdef MUX_ARB_LOCK_EN
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_lock_gnt", 32'(gnt), 32'h20);
    end
    lock = 1'b0;
    tick();
    check("t6_unlock_gnt", 32'(gnt), 32'h40);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_hold_gnt", 32'(gnt), 32'h20);
    end
    tick();
    check("t6_rot_gnt", 32'(gnt), 32'h40);
    check("t6_rot_sel", 32'(sel), 32'd6);
`endif

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
